// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected classifier chain.
// Holds score format constants, the class count, the argmax FSM state
// type and the signed score type used by fc_argmax and its neighbours.
package fc_pkg;

  localparam int unsigned FC_DATA_W      = 16;
  localparam int unsigned FC_FRAC_BITS   = 8;
  localparam int unsigned FC_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } fc_state_e;

  typedef logic signed [FC_DATA_W-1:0] fc_score_t;

endpackage

// File: rtl/fc_rise_detect.sv
// Rising-edge detector for the level-held start flag.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   sig_i  - level input
//   rise_c - combinational pulse: sig_i high now, low on the previous cycle
module fc_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_c
);

  logic sig_q;

  // Reset seeds the history with the live level so that a flag already
  // high when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= sig_i;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_c = sig_i & ~sig_q;

endmodule

// File: rtl/fc_argmax.sv
// Classifier output stage: captures the packed score vector on a rising
// edge of start and scans it serially with one comparator, reporting the
// index and value of the largest signed score with a level done flag.
// Optional: define FC_ARGMAX_MARGIN_EN to add the best-minus-second-best
// margin output.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   start       - level flag from the last FC layer; rising edge triggers
//   in_scores   - packed signed scores, class i at [i*DATA_W +: DATA_W]
//   class_idx   - index of the maximum score
//   class_score - maximum score
//   busy        - capture/scan in progress
//   done        - result valid, held until next capture or reset
//   margin      - (optional) best - second best, unsigned DATA_W+1 bits
module fc_argmax
  import fc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = FC_NUM_CLASSES,
  parameter int unsigned DATA_W      = FC_DATA_W,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CLASSES*DATA_W-1:0] in_scores,
  output logic [IDX_W-1:0]              class_idx,
  output logic [DATA_W-1:0]             class_score,
`ifdef FC_ARGMAX_MARGIN_EN
  output logic [DATA_W:0]               margin,
`endif
  output logic                          busy,
  output logic                          done
);

  logic trigger_c;

  fc_rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (start),
    .rise_c (trigger_c)
  );

  fc_state_e                state_q, state_d;
  logic signed [DATA_W-1:0] scores_q [NUM_CLASSES];
  logic signed [DATA_W-1:0] scores_d [NUM_CLASSES];
  logic signed [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         class_idx_q, class_idx_d;
  logic [DATA_W-1:0]        class_score_q, class_score_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Single comparator datapath: current candidate against running best.
  logic signed [DATA_W-1:0] cand_c;
  logic                     greater_c;
  logic signed [DATA_W-1:0] nb_val_c;
  logic [IDX_W-1:0]         nb_idx_c;
  logic                     last_c;

  assign cand_c    = scores_q[cnt_q];
  assign greater_c = cand_c > best_val_q;
  assign nb_val_c  = greater_c ? cand_c : best_val_q;
  assign nb_idx_c  = greater_c ? cnt_q  : best_idx_q;
  assign last_c    = (cnt_q == IDX_W'(NUM_CLASSES - 1));

`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0] second_q, second_d;
  logic signed [DATA_W-1:0] nb_second_c;
  logic [DATA_W:0]          margin_q, margin_d;

  // A displaced best becomes second; otherwise the candidate may still beat second.
  assign nb_second_c = greater_c          ? best_val_q :
                       (cand_c > second_q) ? cand_c     : second_q;
  assign margin      = margin_q;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    scores_d      = scores_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    cnt_d         = cnt_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    busy_d        = busy_q;
    done_d        = done_q;
`ifdef FC_ARGMAX_MARGIN_EN
    second_d      = second_q;
    margin_d      = margin_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (trigger_c) begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            scores_d[i] = in_scores[i*DATA_W +: DATA_W];
          end
          best_val_d = in_scores[DATA_W-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = ST_SCAN;
`ifdef FC_ARGMAX_MARGIN_EN
          second_d   = {1'b1, {(DATA_W-1){1'b0}}};
`endif
        end
      end
      ST_SCAN: begin
        best_val_d = nb_val_c;
        best_idx_d = nb_idx_c;
        cnt_d      = cnt_q + IDX_W'(1);
`ifdef FC_ARGMAX_MARGIN_EN
        second_d   = nb_second_c;
`endif
        if (last_c) begin
          state_d       = ST_DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          class_idx_d   = nb_idx_c;
          class_score_d = nb_val_c;
`ifdef FC_ARGMAX_MARGIN_EN
          // Sign-extend both to DATA_W+1; best >= second so the result is non-negative.
          margin_d      = {nb_val_c[DATA_W-1], nb_val_c} - {nb_second_c[DATA_W-1], nb_second_c};
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        scores_q[i] <= '0;
      end
      best_val_q    <= '0;
      best_idx_q    <= '0;
      cnt_q         <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q      <= '0;
      margin_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      scores_q      <= scores_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      cnt_q         <= cnt_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q      <= second_d;
      margin_q      <= margin_d;
`endif
    end
  end

  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: table of score vectors with expected
// winner, plus directed sequences for held start, retrigger during scan,
// retrigger in DONE and reset mid-scan.
module tb_fc_argmax;
  import fc_pkg::*;

  localparam int unsigned NC = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NC*DW-1:0] in_scores;
  logic [IW-1:0]    class_idx;
  logic [DW-1:0]    class_score;
  logic             busy;
  logic             done;
`ifdef FC_ARGMAX_MARGIN_EN
  logic [DW:0]      margin;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_scores   (in_scores),
    .class_idx   (class_idx),
    .class_score (class_score),
`ifdef FC_ARGMAX_MARGIN_EN
    .margin      (margin),
`endif
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    string            name;
    logic [NC*DW-1:0] scores;
    logic [IW-1:0]    idx;
    logic [DW-1:0]    score;
    logic [DW:0]      marg;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [NC*DW-1:0] mk(
    input logic [DW-1:0] s0, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
    input logic [DW-1:0] s3, input logic [DW-1:0] s4, input logic [DW-1:0] s5,
    input logic [DW-1:0] s6, input logic [DW-1:0] s7, input logic [DW-1:0] s8,
    input logic [DW-1:0] s9);
    return {s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps until done is seen or a cycle budget runs out; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic classify(input vec_t v);
    int n;
    in_scores = v.scores;
    start     = 1'b1;
    step();
    chk({v.name, " busy after capture"}, 32'(busy), 32'd1);
    chk({v.name, " done after capture"}, 32'(done), 32'd0);
    wait_done(n);
    chk({v.name, " latency"}, 32'(n), 32'd9);
    chk({v.name, " idx"}, 32'(class_idx), 32'(v.idx));
    chk({v.name, " score"}, 32'(class_score), 32'(v.score));
    chk({v.name, " busy at done"}, 32'(busy), 32'd0);
`ifdef FC_ARGMAX_MARGIN_EN
    chk({v.name, " margin"}, 32'(margin), 32'(v.marg));
`endif
    start = 1'b0;
    step();
    chk({v.name, " done held"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int busy_cycles;
    int done_cycles;

    vecs[0] = '{"basic", mk(16'h0100, 16'h0300, 16'hFF00, 16'h0200, 16'h0000,
                            16'h0050, 16'h0010, 16'h0020, 16'h0030, 16'h0040),
                4'd1, 16'h0300, 17'h00100};
    vecs[1] = '{"allneg", mk(16'hFF00, 16'hFE00, 16'h8000, 16'hFF00, 16'hF000,
                             16'hFE80, 16'hC000, 16'hFFF0, 16'hFF00, 16'h9000),
                4'd7, 16'hFFF0, 17'h000F0};
    vecs[2] = '{"tie", mk(16'h0100, 16'h0200, 16'h0000, 16'h0500, 16'h04FF,
                          16'hFFFF, 16'h0300, 16'h0010, 16'h0500, 16'h0400),
                4'd3, 16'h0500, 17'h00000};
    vecs[3] = '{"lastwins", mk(16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF),
                4'd9, 16'h7FFF, 17'h07FFF};
    vecs[4] = '{"firstwins", mk(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000),
                4'd0, 16'h7FFF, 17'h0FFFF};

    // Reset with start already high: no classification may follow release.
    rst       = 1'b1;
    start     = 1'b1;
    in_scores = vecs[0].scores;
    step();
    step();
    chk("reset idx", 32'(class_idx), 32'd0);
    chk("reset score", 32'(class_score), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
`ifdef FC_ARGMAX_MARGIN_EN
    chk("reset margin", 32'(margin), 32'd0);
`endif
    rst = 1'b0;
    step();
    step();
    chk("held start at release busy", 32'(busy), 32'd0);
    chk("held start at release done", 32'(done), 32'd0);
    start = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      classify(vecs[i]);
    end

    // Start held high for 30 cycles, inputs changed after capture.
    in_scores = vecs[0].scores;
    start     = 1'b1;
    step();
    in_scores   = vecs[1].scores;
    busy_cycles = 0;
    done_cycles = 0;
    for (int i = 0; i < 29; i++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_cycles++;
      step();
    end
    chk("held start busy cycles", 32'(busy_cycles), 32'd9);
    chk("held start done cycles", 32'(done_cycles), 32'd20);
    chk("held start idx", 32'(class_idx), 32'd1);
    chk("held start score", 32'(class_score), 32'h0300);
    start = 1'b0;
    step();
    chk("held start done after fall", 32'(done), 32'd1);

    // Second rising edge at C+4 is ignored.
    in_scores = vecs[2].scores;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    in_scores = vecs[0].scores;
    start     = 1'b1;
    step();
    chk("retrig scan busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("retrig scan remaining latency", 32'(n), 32'd5);
    chk("retrig scan idx", 32'(class_idx), 32'd3);
    chk("retrig scan score", 32'(class_score), 32'h0500);
    step();
    step();
    chk("retrig scan done held", 32'(done), 32'd1);

    // Rising edge in DONE recaptures.
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("retrig done drops", 32'(done), 32'd0);
    chk("retrig done busy", 32'(busy), 32'd1);
    chk("retrig done idx held", 32'(class_idx), 32'd3);
    wait_done(n);
    chk("retrig done latency", 32'(n), 32'd9);
    chk("retrig done idx", 32'(class_idx), 32'd1);
    chk("retrig done score", 32'(class_score), 32'h0300);
    start = 1'b0;
    step();

    // Reset at C+5 abandons the scan.
    in_scores = vecs[1].scores;
    start     = 1'b1;
    step();
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midscan reset idx", 32'(class_idx), 32'd0);
    chk("midscan reset score", 32'(class_score), 32'd0);
    chk("midscan reset busy", 32'(busy), 32'd0);
    chk("midscan reset done", 32'(done), 32'd0);
`ifdef FC_ARGMAX_MARGIN_EN
    chk("midscan reset margin", 32'(margin), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("after reset no partial done", 32'(done), 32'd0);
    chk("after reset idle busy", 32'(busy), 32'd0);
    start = 1'b0;
    step();
    classify(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
